// File: rtl/stream_slicer_pkg.sv
// Shared types and helpers for the stream slicer: capture-FSM state encoding
// and a constant-foldable ceil(log2) used to size counters and pointers.
package stream_slicer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cap_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_slicer_if.sv
// Upstream four-phase word handshake plus downstream slice stream of the slicer.
// master = upstream source / consumer side, slave = the slicer itself.
interface stream_slicer_if
    import stream_slicer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned DEPTH     = 2
);
    logic                   data_valid;
    logic [IN_WIDTH-1:0]    data_in;
    logic                   ack;
    logic                   read;
    logic                   data_valid_out;
    logic [OUT_WIDTH-1:0]   byte_out;
    logic [clog2(DEPTH):0]  words_buffered;

    modport master (
        output data_valid, data_in, read,
        input  ack, data_valid_out, byte_out, words_buffered
    );

    modport slave (
        input  data_valid, data_in, read,
        output ack, data_valid_out, byte_out, words_buffered
    );

endinterface

// File: rtl/slicer_word_fifo.sv
// Synchronous DEPTH x WIDTH word buffer with first-word-fall-through read port.
// A push into a full buffer is accepted only when a pop happens on the same edge.
module slicer_word_fifo
    import stream_slicer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = (AW == 0) ? 1 : AW;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps DEPTH == 1 correct where the pointer has a spare bit
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/stream_slicer.sv
// Captures words from a four-phase upstream, buffers them and emits OUT_WIDTH slices.
// Define STREAM_SLICER_CDC_SYNC_EN to pass data_valid through a two-flop synchroniser.
module stream_slicer
    import stream_slicer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic           clk,
    input  logic           restart,
    stream_slicer_if.slave bus
);
    localparam int unsigned SLICES = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned IW     = (clog2(SLICES) == 0) ? 1 : clog2(SLICES);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_config
        $error("stream_slicer: IN_WIDTH must be a multiple of OUT_WIDTH and DEPTH a power of two");
    end

    logic                 dv_s;
    cap_state_t           state;
    cap_state_t           state_next;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 can_push;
    logic [IN_WIDTH-1:0]  fifo_dout;
    logic [clog2(DEPTH):0] fifo_count;
    logic [IN_WIDTH-1:0]  word_q;
    logic [IW-1:0]        idx;
    logic                 out_valid;
    logic                 advance;
    logic                 last;

`ifdef STREAM_SLICER_CDC_SYNC_EN
    (* ASYNC_REG = "TRUE" *) logic dv_meta;
    (* ASYNC_REG = "TRUE" *) logic dv_sync;

    always_ff @(posedge clk) begin
        if (restart) begin
            dv_meta <= 1'b0;
            dv_sync <= 1'b0;
        end else begin
            dv_meta <= bus.data_valid;
            dv_sync <= dv_meta;
        end
    end

    assign dv_s = dv_sync;
`else
    assign dv_s = bus.data_valid;
`endif

    slicer_word_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (restart),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign can_push = !fifo_full || fifo_pop;

    always_ff @(posedge clk) begin
        if (restart) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dv_s && can_push) state_next = HOLD;
            HOLD:    if (!dv_s)            state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_push = (state == IDLE) && dv_s && can_push;
        bus.ack   = (state == HOLD);
    end

    assign advance  = out_valid && bus.read;
    assign last     = (idx == IW'(SLICES - 1));
    assign fifo_pop = !fifo_empty && (!out_valid || (advance && last));

    // word_q shifts so the current slice always sits at a fixed end; idx only tracks the boundary
    always_ff @(posedge clk) begin
        if (restart) begin
            out_valid <= 1'b0;
            idx       <= '0;
            word_q    <= '0;
        end else if (fifo_pop) begin
            out_valid <= 1'b1;
            idx       <= '0;
            word_q    <= fifo_dout;
        end else if (advance) begin
            if (last) begin
                out_valid <= 1'b0;
                idx       <= '0;
            end else begin
                idx    <= idx + IW'(1);
                word_q <= (MSB_FIRST != 0) ? (word_q << OUT_WIDTH) : (word_q >> OUT_WIDTH);
            end
        end
    end

    if (MSB_FIRST != 0) begin : g_msb_first
        assign bus.byte_out = word_q[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb_first
        assign bus.byte_out = word_q[OUT_WIDTH-1:0];
    end

    assign bus.data_valid_out = out_valid;
    assign bus.words_buffered = fifo_count;

endmodule

// File: tb/tb_stream_slicer.sv
// Self-checking bench: an MSB-first and an LSB-first slicer share stimulus and are
// compared against per-word slice queues built from the arithmetic slice rule.
module tb_stream_slicer;
    import stream_slicer_pkg::*;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned DEP   = 2;
    localparam int unsigned SL    = IN_W / OUT_W;
`ifdef STREAM_SLICER_CDC_SYNC_EN
    localparam int CAP_LAT = 3;
`else
    localparam int CAP_LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            restart;
    logic            data_valid;
    logic            read;
    logic [IN_W-1:0] data_in;

    int n_checks = 0;
    int n_pass   = 0;

    logic [OUT_W-1:0] exp_a[$];
    logic [OUT_W-1:0] exp_b[$];

    stream_slicer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEP)) bus_a ();
    stream_slicer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEP)) bus_b ();

    assign bus_a.data_valid = data_valid;
    assign bus_a.data_in    = data_in;
    assign bus_a.read       = read;
    assign bus_b.data_valid = data_valid;
    assign bus_b.data_in    = data_in;
    assign bus_b.read       = read;

    stream_slicer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEP), .MSB_FIRST(1)) dut_a (
        .clk(clk), .restart(restart), .bus(bus_a.slave));
    stream_slicer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEP), .MSB_FIRST(0)) dut_b (
        .clk(clk), .restart(restart), .bus(bus_b.slave));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: a word contributes SL slices, ordered by significance
    function automatic void model_push(input logic [IN_W-1:0] w);
        for (int unsigned s = 0; s < SL; s++) begin
            exp_a.push_back(w[IN_W-1-s*OUT_W -: OUT_W]);
            exp_b.push_back(w[s*OUT_W +: OUT_W]);
        end
    endfunction

    // Drive read for one cycle; a slice visible with data_valid_out is consumed now
    task automatic step(input logic rd);
        read = rd;
        if (rd && bus_a.data_valid_out) begin
            n_checks++;
            if (exp_a.size() == 0)
                $display("FAIL slice_msb: got %h, required no slice", bus_a.byte_out);
            else if (bus_a.byte_out !== exp_a[0])
                $display("FAIL slice_msb: got %h, required %h", bus_a.byte_out, exp_a[0]);
            else n_pass++;
            n_checks++;
            if (exp_b.size() == 0)
                $display("FAIL slice_lsb: got %h, required no slice", bus_b.byte_out);
            else if (bus_b.byte_out !== exp_b[0] || bus_b.data_valid_out !== 1'b1)
                $display("FAIL slice_lsb: got %h dv %b, required %h dv 1", bus_b.byte_out, bus_b.data_valid_out, exp_b[0]);
            else n_pass++;
            if (exp_a.size() > 0) void'(exp_a.pop_front());
            if (exp_b.size() > 0) void'(exp_b.pop_front());
        end
        @(negedge clk);
    endtask

    // Full four-phase transfer; ok reports ack seen and then released
    task automatic offer(input logic [IN_W-1:0] w, output bit ok);
        bit acked;
        acked = 0;
        data_in = w;
        data_valid = 1'b1;
        for (int n = 0; n < 40 && !acked; n++) begin
            @(negedge clk);
            if (bus_a.ack) acked = 1;
        end
        if (acked) model_push(w);
        data_valid = 1'b0;
        for (int n = 0; n < 40 && bus_a.ack; n++) @(negedge clk);
        ok = acked && !bus_a.ack;
    endtask

    task automatic test_reset();
        restart = 1'b1; data_valid = 1'b0; read = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_a.ack !== 1'b0) $display("FAIL reset_ack: got %b, required 0", bus_a.ack); else n_pass++;
        n_checks++;
        if (bus_a.data_valid_out !== 1'b0 || bus_b.data_valid_out !== 1'b0)
            $display("FAIL reset_dvo: got %b/%b, required 0/0", bus_a.data_valid_out, bus_b.data_valid_out);
        else n_pass++;
        n_checks++;
        if (bus_a.words_buffered !== 2'd0) $display("FAIL reset_words: got %0d, required 0", bus_a.words_buffered); else n_pass++;
        restart = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int lat;
        lat = -1;
        read = 1'b0;
        data_in = 32'h11223344;
        data_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus_a.ack) begin lat = n; break; end
        end
        n_checks++;
        if (lat != CAP_LAT) $display("FAIL capture_latency: got %0d, required %0d", lat, CAP_LAT); else n_pass++;
        n_checks++;
        if (bus_a.data_valid_out !== 1'b0) $display("FAIL dvo_at_capture: got %b, required 0", bus_a.data_valid_out); else n_pass++;
        model_push(data_in);
        data_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_a.data_valid_out !== 1'b1) $display("FAIL dvo_after_load: got %b, required 1", bus_a.data_valid_out); else n_pass++;
        for (int s = 0; s < int'(SL); s++) step(1'b1);
        read = 1'b0;
        n_checks++;
        if (bus_a.data_valid_out !== 1'b0 || exp_a.size() != 0)
            $display("FAIL dvo_after_last: got dv %b pending %0d, required dv 0 pending 0", bus_a.data_valid_out, exp_a.size());
        else n_pass++;
        for (int n = 0; n < 40 && bus_a.ack; n++) @(negedge clk);
        n_checks++;
        if (bus_a.ack !== 1'b0) $display("FAIL ack_release: got %b, required 0", bus_a.ack); else n_pass++;
    endtask

    task automatic test_long_valid();
        int rises;
        int peak;
        logic prev;
        rises = 0; peak = 0; prev = 1'b0;
        read = 1'b0;
        data_in = $urandom;
        data_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus_a.ack && !prev) begin rises++; model_push(data_in); end
            prev = bus_a.ack;
            if (int'(bus_a.words_buffered) > peak) peak = int'(bus_a.words_buffered);
        end
        data_valid = 1'b0;
        for (int n = 0; n < 40 && bus_a.ack; n++) @(negedge clk);
        n_checks++;
        if (rises != 1) $display("FAIL long_valid_captures: got %0d, required 1", rises); else n_pass++;
        n_checks++;
        if (peak != 1) $display("FAIL long_valid_peak: got %0d, required 1", peak); else n_pass++;
        for (int s = 0; s < int'(SL) + 2; s++) step(1'b1);
        read = 1'b0;
        n_checks++;
        if (exp_a.size() != 0 || bus_a.data_valid_out !== 1'b0)
            $display("FAIL long_valid_drain: pending %0d dv %b, required 0 and 0", exp_a.size(), bus_a.data_valid_out);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int gaps;
        logic [IN_W-1:0] w4;
        read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            offer($urandom, ok);
            n_checks++;
            if (!ok) $display("FAIL bp_offer: word %0d got no handshake, required ack", k); else n_pass++;
        end
        n_checks++;
        if (bus_a.words_buffered !== 2'd2 || bus_a.data_valid_out !== 1'b1)
            $display("FAIL bp_full: words %0d dv %b, required 2 and 1", bus_a.words_buffered, bus_a.data_valid_out);
        else n_pass++;
        w4 = $urandom;
        data_in = w4;
        data_valid = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (bus_a.ack !== 1'b0) $display("FAIL bp_blocked: ack %b, required 0", bus_a.ack); else n_pass++;
        for (int i = 1; i <= int'(SL); i++) begin
            step(1'b1);
            n_checks++;
            if (bus_a.ack !== (i == int'(SL)))
                $display("FAIL bp_ack_after_reads: read %0d ack %b, required %b", i, bus_a.ack, (i == int'(SL)));
            else n_pass++;
        end
        if (bus_a.ack) model_push(w4);
        data_valid = 1'b0;
        gaps = 0;
        for (int n = 0; n < 40 && exp_a.size() > 0; n++) begin
            if (bus_a.data_valid_out !== 1'b1) gaps++;
            step(1'b1);
        end
        read = 1'b0;
        n_checks++;
        if (gaps != 0 || exp_a.size() != 0)
            $display("FAIL bp_drain: gaps %0d pending %0d, required 0 and 0", gaps, exp_a.size());
        else n_pass++;
        for (int n = 0; n < 40 && bus_a.ack; n++) @(negedge clk);
        n_checks++;
        if (bus_a.data_valid_out !== 1'b0 || bus_a.words_buffered !== 2'd0 || bus_a.ack !== 1'b0)
            $display("FAIL bp_idle: dv %b words %0d ack %b, required 0 0 0",
                     bus_a.data_valid_out, bus_a.words_buffered, bus_a.ack);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gaps;
        read = 1'b0;
        for (int k = 0; k < 2; k++) begin
            offer($urandom, ok);
            n_checks++;
            if (!ok) $display("FAIL b2b_offer: word %0d got no handshake, required ack", k); else n_pass++;
        end
        gaps = 0;
        for (int s = 0; s < 2 * int'(SL); s++) begin
            if (bus_a.data_valid_out !== 1'b1) gaps++;
            step(1'b1);
        end
        read = 1'b0;
        n_checks++;
        if (gaps != 0 || exp_a.size() != 0 || bus_a.data_valid_out !== 1'b0)
            $display("FAIL b2b_stream: gaps %0d pending %0d dv %b, required 0 0 0", gaps, exp_a.size(), bus_a.data_valid_out);
        else n_pass++;
    endtask

    task automatic test_restart();
        bit ok;
        int lat;
        offer($urandom, ok);
        n_checks++;
        if (!ok) $display("FAIL rst_offer: no handshake, required ack"); else n_pass++;
        step(1'b1);
        step(1'b1);
        read = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.data_valid_out !== 1'b0 || bus_b.data_valid_out !== 1'b0 || bus_a.ack !== 1'b0 || bus_a.words_buffered !== 2'd0)
            $display("FAIL rst_mid_word: dv %b/%b ack %b words %0d, required 0/0 0 0",
                     bus_a.data_valid_out, bus_b.data_valid_out, bus_a.ack, bus_a.words_buffered);
        else n_pass++;
        restart = 1'b0;
        exp_a.delete();
        exp_b.delete();
        offer($urandom, ok);
        n_checks++;
        if (!ok) $display("FAIL rst_reoffer: no handshake, required ack"); else n_pass++;
        for (int s = 0; s < int'(SL); s++) step(1'b1);
        read = 1'b0;
        n_checks++;
        if (exp_a.size() != 0 || bus_a.data_valid_out !== 1'b0)
            $display("FAIL rst_reoffer_stream: pending %0d dv %b, required 0 and 0", exp_a.size(), bus_a.data_valid_out);
        else n_pass++;

        // data_valid held across restart: the discarded capture is taken again
        data_in = $urandom;
        data_valid = 1'b1;
        for (int n = 0; n < 20 && !bus_a.ack; n++) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_checks++;
        if (bus_a.ack !== 1'b0 || bus_a.words_buffered !== 2'd0)
            $display("FAIL rst_held_clear: ack %b words %0d, required 0 and 0", bus_a.ack, bus_a.words_buffered);
        else n_pass++;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus_a.ack) begin lat = n; break; end
        end
        n_checks++;
        if (lat != CAP_LAT) $display("FAIL rst_held_latency: got %0d, required %0d", lat, CAP_LAT); else n_pass++;
        if (lat > 0) model_push(data_in);
        data_valid = 1'b0;
        for (int s = 0; s < int'(SL) + 2; s++) step(1'b1);
        read = 1'b0;
        n_checks++;
        if (exp_a.size() != 0 || bus_a.data_valid_out !== 1'b0)
            $display("FAIL rst_held_stream: pending %0d dv %b, required 0 and 0", exp_a.size(), bus_a.data_valid_out);
        else n_pass++;
        for (int n = 0; n < 40 && bus_a.ack; n++) @(negedge clk);
    endtask

    task automatic test_random();
        int over;
        int words;
        over = 0;
        words = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (data_valid && bus_a.ack) begin
                model_push(data_in);
                words++;
                data_valid = 1'b0;
            end else if (!data_valid && !bus_a.ack && $urandom_range(0, 3) == 0) begin
                data_in = $urandom;
                data_valid = 1'b1;
            end
            if (int'(bus_a.words_buffered) > int'(DEP)) over++;
            step(1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 200; n++) begin
            if (data_valid && bus_a.ack) begin
                model_push(data_in);
                words++;
                data_valid = 1'b0;
            end
            if (!data_valid && !bus_a.ack && exp_a.size() == 0 && !bus_a.data_valid_out) break;
            step(1'b1);
        end
        read = 1'b0;
        n_checks++;
        if (over != 0) $display("FAIL rand_occupancy: %0d cycles above %0d, required 0", over, DEP); else n_pass++;
        n_checks++;
        if (words < 20) $display("FAIL rand_traffic: %0d words, required at least 20", words); else n_pass++;
        n_checks++;
        if (exp_a.size() != 0 || bus_a.data_valid_out !== 1'b0 || bus_a.words_buffered !== 2'd0)
            $display("FAIL rand_drain: pending %0d dv %b words %0d, required 0 0 0",
                     exp_a.size(), bus_a.data_valid_out, bus_a.words_buffered);
        else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_word();
        test_long_valid();
        test_backpressure();
        test_back_to_back();
        test_restart();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
